// File: rtl/spi_axi_pkg.sv
// Shared opcodes, status bit positions, FSM state types and frame sizing for the SPI to AXI4-Lite bridge.
package spi_axi_pkg;

    localparam logic [1:0] OP_STATUS = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_RDATA  = 2'b11;

    localparam int ST_BUSY  = 0;
    localparam int ST_WBUSY = 1;
    localparam int ST_RBUSY = 2;
    localparam int ST_OVR   = 3;
    localparam int ST_RESP  = 4;
    localparam int ST_ERR   = 6;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 2 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_frontend_sync.sv
// SPI slave front end: synchronises SCLK/CEB/MOSI into CLK, counts frame bits, shifts MOSI in and MISO out.
// Latency: about SYNC_STAGES+1 CLK from a pin edge to its effect; no backpressure, the host paces the frame.
module spi_frontend_sync
    import spi_axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = $clog2(frame_len(ADDR_W, DATA_W) + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_ceb,
    input  logic              spi_sclk,
    input  logic              spi_data,
    input  logic [DATA_W-1:0] status_dat,
    input  logic [DATA_W-1:0] rdata_dat,
    output logic              spi_dout,
    output logic              frame_end,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [1:0]        frame_op,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_dat
);
    localparam int PAY_W = ADDR_W + DATA_W;

    logic [SYNC_STAGES-1:0] sclk_sync, ceb_sync, data_sync;
    logic                   sclk_d, ceb_d;
    logic                   sclk_s, ceb_s, data_s;
    logic                   sclk_rise, sclk_fall;
    logic [PAY_W-1:0]       mosi_sr;
    logic [DATA_W-1:0]      miso_sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ceb_sync  <= '1;
            data_sync <= '0;
            sclk_d    <= 1'b0;
            ceb_d     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ceb_sync  <= {ceb_sync[SYNC_STAGES-2:0], spi_ceb};
            data_sync <= {data_sync[SYNC_STAGES-2:0], spi_data};
            sclk_d    <= sclk_s;
            ceb_d     <= ceb_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ceb_s     = ceb_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign frame_end = ceb_s & ~ceb_d;

    // Frame registers are wiped while CEB is high; the frame_end cycle still sees the final values.
    always_ff @(posedge clk) begin
        if (rst || ceb_s) begin
            frame_cnt <= '0;
            frame_op  <= '0;
            mosi_sr   <= '0;
            miso_sr   <= '0;
            spi_dout  <= 1'b0;
        end else if (sclk_rise) begin
            if (frame_cnt != '1)
                frame_cnt <= frame_cnt + CNT_W'(1);
            mosi_sr <= {mosi_sr[PAY_W-2:0], data_s};
            if (frame_cnt < CNT_W'(2))
                frame_op <= {frame_op[0], data_s};
            if (frame_cnt == CNT_W'(1)) begin
                case ({frame_op[0], data_s})
                    OP_STATUS: miso_sr <= status_dat;
                    OP_RDATA:  miso_sr <= rdata_dat;
                    default:   miso_sr <= '0;
                endcase
            end
        end else if (sclk_fall) begin
            spi_dout <= miso_sr[DATA_W-1];
            miso_sr  <= {miso_sr[DATA_W-2:0], 1'b0};
        end
    end

    assign frame_addr = mosi_sr[PAY_W-1:DATA_W];
    assign frame_dat  = mosi_sr[DATA_W-1:0];

endmodule

// File: rtl/spi_axi_lite_bridge.sv
// SPI host to AXI4-Lite master bridge: one single-beat read or write per SPI frame, plus status/control access.
// Latency: AXI request starts 1 CLK after the detected CEB rise; AXI stalls show as BUSY, frames sent while busy set OVR.
// Optional SPI_AXI_RESP_EN adds M_BRESP/M_RRESP capture into status[5:4] and a sticky ERR flag in status[6].
module spi_axi_lite_bridge
    import spi_axi_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [CTRL_W-1:0] CTRL_RST    = '0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                SPI_CEB,
    input  logic                SPI_SCLK,
    input  logic                SPI_DATA,
    output logic                SPI_DOUT,
    output logic [CTRL_W-1:0]   CTRL_OUT,
    output logic [ADDR_W-1:0]   M_AWADDR,
    output logic                M_AWVALID,
    input  logic                M_AWREADY,
    output logic [DATA_W-1:0]   M_WDATA,
    output logic [DATA_W/8-1:0] M_WSTRB,
    output logic                M_WVALID,
    input  logic                M_WREADY,
    input  logic                M_BVALID,
    output logic                M_BREADY,
    output logic [ADDR_W-1:0]   M_ARADDR,
    output logic                M_ARVALID,
    input  logic                M_ARREADY,
    input  logic [DATA_W-1:0]   M_RDATA,
    input  logic                M_RVALID,
    output logic                M_RREADY,
    output logic [2:0]          M_AWPROT,
    output logic [2:0]          M_ARPROT
`ifdef SPI_AXI_RESP_EN
    ,
    input  logic [1:0]          M_BRESP,
    input  logic [1:0]          M_RRESP
`endif
);
    localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);

    wr_state_t         w_state, w_next;
    rd_state_t         r_state, r_next;
    logic              frame_end;
    logic [CNT_W-1:0]  frame_cnt;
    logic [1:0]        frame_op;
    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_dat;
    logic [DATA_W-1:0] status_word, rdata_q;
    logic              wbusy, rbusy, busy, ovr_q;
    logic              full_frame, wr_launch, rd_launch, overrun, status_done, ctrl_load;

    spi_frontend_sync #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_W      (CNT_W)
    ) u_frontend (
        .clk       (CLK),
        .rst       (RST),
        .spi_ceb   (SPI_CEB),
        .spi_sclk  (SPI_SCLK),
        .spi_data  (SPI_DATA),
        .status_dat(status_word),
        .rdata_dat (rdata_q),
        .spi_dout  (SPI_DOUT),
        .frame_end (frame_end),
        .frame_cnt (frame_cnt),
        .frame_op  (frame_op),
        .frame_addr(frame_addr),
        .frame_dat (frame_dat)
    );

    assign wbusy       = (w_state != W_IDLE);
    assign rbusy       = (r_state != R_IDLE);
    assign busy        = wbusy | rbusy;
    assign full_frame  = frame_end && (frame_cnt == CNT_W'(FRAME_LEN));
    assign wr_launch   = full_frame && (frame_op == OP_WRITE) && !busy;
    assign rd_launch   = full_frame && (frame_op == OP_READ) && !busy;
    assign overrun     = full_frame && (frame_op == OP_WRITE || frame_op == OP_READ) && busy;
    assign status_done = frame_end && (frame_op == OP_STATUS) && (frame_cnt >= CNT_W'(2 + DATA_W));
    assign ctrl_load   = full_frame && (frame_op == OP_STATUS);

    assign M_WSTRB  = '1;
    assign M_AWPROT = 3'b000;
    assign M_ARPROT = 3'b000;

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    // AW and W complete independently; a channel whose VALID already dropped counts as done.
    always_comb begin
        w_next   = w_state;
        M_BREADY = 1'b0;
        case (w_state)
            W_IDLE: if (wr_launch) w_next = W_ADDR;
            W_ADDR: if ((!M_AWVALID || M_AWREADY) && (!M_WVALID || M_WREADY)) w_next = W_RESP;
            W_RESP: begin
                M_BREADY = 1'b1;
                if (M_BVALID) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next    = r_state;
        M_ARVALID = 1'b0;
        M_RREADY  = 1'b0;
        case (r_state)
            R_IDLE: if (rd_launch) r_next = R_ADDR;
            R_ADDR: begin
                M_ARVALID = 1'b1;
                if (M_ARREADY) r_next = R_DATA;
            end
            R_DATA: begin
                M_RREADY = 1'b1;
                if (M_RVALID) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            M_AWVALID <= 1'b0;
            M_WVALID  <= 1'b0;
            M_AWADDR  <= '0;
            M_WDATA   <= '0;
            M_ARADDR  <= '0;
            rdata_q   <= '0;
        end else begin
            if (wr_launch) begin
                M_AWVALID <= 1'b1;
                M_WVALID  <= 1'b1;
                M_AWADDR  <= frame_addr;
                M_WDATA   <= frame_dat;
            end else begin
                if (M_AWREADY) M_AWVALID <= 1'b0;
                if (M_WREADY)  M_WVALID  <= 1'b0;
            end
            if (rd_launch)
                M_ARADDR <= frame_addr;
            if (r_state == R_DATA && M_RVALID)
                rdata_q <= M_RDATA;
        end
    end

`ifdef SPI_AXI_RESP_EN
    logic [1:0] resp_q;
    logic       err_q;
    logic       b_hs, r_hs;

    assign b_hs = (w_state == W_RESP) && M_BVALID;
    assign r_hs = (r_state == R_DATA) && M_RVALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            resp_q <= RESP_OKAY;
            err_q  <= 1'b0;
        end else begin
            if (status_done) err_q <= 1'b0;
            if (b_hs) begin
                resp_q <= M_BRESP;
                if (M_BRESP != RESP_OKAY) err_q <= 1'b1;
            end
            if (r_hs) begin
                resp_q <= M_RRESP;
                if (M_RRESP != RESP_OKAY) err_q <= 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            ovr_q    <= 1'b0;
            CTRL_OUT <= CTRL_RST;
        end else begin
            if (status_done) ovr_q <= 1'b0;
            if (overrun)     ovr_q <= 1'b1;
            if (ctrl_load)   CTRL_OUT <= frame_dat[CTRL_W-1:0];
        end
    end

    always_comb begin
        status_word           = '0;
        status_word[ST_BUSY]  = busy;
        status_word[ST_WBUSY] = wbusy;
        status_word[ST_RBUSY] = rbusy;
        status_word[ST_OVR]   = ovr_q;
`ifdef SPI_AXI_RESP_EN
        status_word[ST_RESP +: 2] = resp_q;
        status_word[ST_ERR]       = err_q;
`endif
    end

endmodule

// File: tb/tb_spi_axi_lite_bridge.sv
// Directed bench for spi_axi_lite_bridge: SPI host driver, delayed AXI slave responders, table of frames plus corner sequences.
module tb_spi_axi_lite_bridge;

    localparam int HALF = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        SPI_CEB, SPI_SCLK, SPI_DATA, SPI_DOUT;
    logic [0:0]  CTRL_OUT;
    logic [31:0] M_AWADDR, M_WDATA, M_ARADDR, M_RDATA;
    logic [3:0]  M_WSTRB;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [2:0]  M_AWPROT, M_ARPROT;
`ifdef SPI_AXI_RESP_EN
    logic [1:0]  M_BRESP, M_RRESP;
    logic [1:0]  bresp_val = 2'b00;
`endif

    int          checks = 0;
    int          errors = 0;
    int          aw_dly = 3, w_dly = 1, b_dly = 2, ar_dly = 2, r_dly = 5;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
    logic [3:0]  w_strb = '0;
    logic [31:0] rd_val = 32'h0000_02A5;

    always #5 CLK = ~CLK;

    spi_axi_lite_bridge dut (
        .CLK      (CLK),
        .RST      (RST),
        .SPI_CEB  (SPI_CEB),
        .SPI_SCLK (SPI_SCLK),
        .SPI_DATA (SPI_DATA),
        .SPI_DOUT (SPI_DOUT),
        .CTRL_OUT (CTRL_OUT),
        .M_AWADDR (M_AWADDR),
        .M_AWVALID(M_AWVALID),
        .M_AWREADY(M_AWREADY),
        .M_WDATA  (M_WDATA),
        .M_WSTRB  (M_WSTRB),
        .M_WVALID (M_WVALID),
        .M_WREADY (M_WREADY),
        .M_BVALID (M_BVALID),
        .M_BREADY (M_BREADY),
        .M_ARADDR (M_ARADDR),
        .M_ARVALID(M_ARVALID),
        .M_ARREADY(M_ARREADY),
        .M_RDATA  (M_RDATA),
        .M_RVALID (M_RVALID),
        .M_RREADY (M_RREADY),
        .M_AWPROT (M_AWPROT),
        .M_ARPROT (M_ARPROT)
`ifdef SPI_AXI_RESP_EN
        ,
        .M_BRESP  (M_BRESP),
        .M_RRESP  (M_RRESP)
`endif
    );

    // AXI slave responders: READY/VALID raised at a negedge, so the handshake lands on the next posedge.
    initial begin
        M_AWREADY = 1'b0;
        forever begin
            @(negedge CLK);
            if (M_AWVALID) begin
                repeat (aw_dly) @(negedge CLK);
                M_AWREADY = 1'b1;
                aw_cnt++;
                aw_addr = M_AWADDR;
                @(negedge CLK);
                M_AWREADY = 1'b0;
            end
        end
    end

    initial begin
        M_WREADY = 1'b0;
        forever begin
            @(negedge CLK);
            if (M_WVALID) begin
                repeat (w_dly) @(negedge CLK);
                M_WREADY = 1'b1;
                w_cnt++;
                w_data = M_WDATA;
                w_strb = M_WSTRB;
                @(negedge CLK);
                M_WREADY = 1'b0;
            end
        end
    end

    initial begin
        M_BVALID = 1'b0;
`ifdef SPI_AXI_RESP_EN
        M_BRESP = 2'b00;
        M_RRESP = 2'b00;
`endif
        forever begin
            @(negedge CLK);
            if (M_BREADY) begin
                repeat (b_dly) @(negedge CLK);
                M_BVALID = 1'b1;
`ifdef SPI_AXI_RESP_EN
                M_BRESP = bresp_val;
`endif
                @(negedge CLK);
                M_BVALID = 1'b0;
            end
        end
    end

    initial begin
        M_ARREADY = 1'b0;
        forever begin
            @(negedge CLK);
            if (M_ARVALID) begin
                repeat (ar_dly) @(negedge CLK);
                M_ARREADY = 1'b1;
                ar_cnt++;
                ar_addr = M_ARADDR;
                @(negedge CLK);
                M_ARREADY = 1'b0;
            end
        end
    end

    initial begin
        M_RVALID = 1'b0;
        M_RDATA  = '0;
        forever begin
            @(negedge CLK);
            if (M_RREADY) begin
                repeat (r_dly) @(negedge CLK);
                M_RVALID = 1'b1;
                M_RDATA  = rd_val;
                @(negedge CLK);
                M_RVALID = 1'b0;
                M_RDATA  = '0;
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] f66(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        return {62'd0, op, a, d};
    endfunction

    function automatic logic [127:0] f34(input logic [1:0] op, input logic [31:0] d);
        return {94'd0, op, d};
    endfunction

    // Sends nbits MSB-first; MISO is read just before each rise, and bits 2..33 form the returned word.
    task automatic spi_frame(input int nbits, input logic [127:0] bits, output logic [31:0] rx);
        rx = '0;
        @(negedge CLK);
        SPI_CEB = 1'b0;
        repeat (HALF) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            SPI_DATA = bits[nbits-1-i];
            repeat (HALF) @(negedge CLK);
            if (i >= 2 && i < 34) rx[33-i] = SPI_DOUT;
            SPI_SCLK = 1'b1;
            repeat (HALF) @(negedge CLK);
            SPI_SCLK = 1'b0;
        end
        repeat (HALF) @(negedge CLK);
        SPI_CEB  = 1'b1;
        SPI_DATA = 1'b0;
        repeat (2 * HALF) @(negedge CLK);
    endtask

    typedef struct {
        int          nbits;
        logic [127:0] bits;
        logic [31:0] exp_miso;
        logic        exp_ctrl;
        int          exp_aw;
        int          exp_ar;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] rx;

    initial begin
        vecs[0] = '{34, f34(2'b00, 32'h0),                          32'h0,   1'b0, 0, 0};
        vecs[1] = '{66, f66(2'b01, 32'h408, 32'h0),                 32'h0,   1'b0, 0, 1};
        vecs[2] = '{34, f34(2'b11, 32'h0),                          32'h2A5, 1'b0, 0, 1};
        vecs[3] = '{66, f66(2'b00, 32'h0, 32'h1),                   32'h0,   1'b1, 0, 1};
        vecs[4] = '{34, f34(2'b00, 32'h0),                          32'h0,   1'b1, 0, 1};
        vecs[5] = '{40, f66(2'b10, 32'h400, 32'hDEADBEEF) >> 26,    32'h0,   1'b1, 0, 1};
        vecs[6] = '{34, f34(2'b00, 32'h0),                          32'h0,   1'b1, 0, 1};
        vecs[7] = '{66, f66(2'b00, 32'h0, 32'h0),                   32'h0,   1'b0, 0, 1};
        vecs[8] = '{65, f66(2'b01, 32'h40C, 32'h0) >> 1,            32'h0,   1'b0, 0, 1};
        vecs[9] = '{66, f66(2'b11, 32'h0, 32'h0),                   32'h2A5, 1'b0, 0, 1};

        RST      = 1'b1;
        SPI_CEB  = 1'b1;
        SPI_SCLK = 1'b0;
        SPI_DATA = 1'b0;
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_ctrl",    64'(CTRL_OUT),  64'h0);
        check("rst_awvalid", 64'(M_AWVALID), 64'h0);
        check("rst_wvalid",  64'(M_WVALID),  64'h0);
        check("rst_arvalid", 64'(M_ARVALID), 64'h0);
        check("rst_bready",  64'(M_BREADY),  64'h0);
        check("rst_rready",  64'(M_RREADY),  64'h0);
        check("rst_wstrb",   64'(M_WSTRB),   64'hF);
        check("rst_dout",    64'(SPI_DOUT),  64'h0);
        check("rst_prot",    64'({M_AWPROT, M_ARPROT}), 64'h0);

        for (int i = 0; i < 10; i++) begin
            spi_frame(vecs[i].nbits, vecs[i].bits, rx);
            repeat (60) @(negedge CLK);
            check($sformatf("v%0d_miso", i), 64'(rx),       64'(vecs[i].exp_miso));
            check($sformatf("v%0d_ctrl", i), 64'(CTRL_OUT), 64'(vecs[i].exp_ctrl));
            check($sformatf("v%0d_aw", i),   64'(aw_cnt),   64'(vecs[i].exp_aw));
            check($sformatf("v%0d_ar", i),   64'(ar_cnt),   64'(vecs[i].exp_ar));
        end
        check("read_araddr", 64'(ar_addr), 64'h408);

        // Write then poll: long B delay keeps WBUSY visible on the first poll.
        b_dly = 300;
        spi_frame(66, f66(2'b10, 32'h400, 32'hDEADBEEF), rx);
        repeat (20) @(negedge CLK);
        check("wr_aw_cnt", 64'(aw_cnt), 64'd1);
        check("wr_w_cnt",  64'(w_cnt),  64'd1);
        check("wr_awaddr", 64'(aw_addr), 64'h400);
        check("wr_wdata",  64'(w_data),  64'hDEADBEEF);
        check("wr_wstrb",  64'(w_strb),  64'hF);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("wr_poll_busy", 64'(rx), 64'h3);
        repeat (400) @(negedge CLK);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("wr_poll_idle", 64'(rx), 64'h0);

        // Overrun: second write lands while the first still waits for B.
        b_dly = 2000;
        spi_frame(66, f66(2'b10, 32'h404, 32'h11111111), rx);
        spi_frame(66, f66(2'b10, 32'h408, 32'h22222222), rx);
        repeat (20) @(negedge CLK);
        check("ovr_aw_cnt", 64'(aw_cnt),  64'd2);
        check("ovr_awaddr", 64'(aw_addr), 64'h404);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("ovr_poll_set", 64'(rx), 64'hB);
        repeat (2200) @(negedge CLK);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("ovr_poll_clr", 64'(rx), 64'h0);

        b_dly = 2;
`ifdef SPI_AXI_RESP_EN
        bresp_val = 2'b10;
        spi_frame(66, f66(2'b10, 32'h410, 32'h5), rx);
        repeat (50) @(negedge CLK);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("resp_err_set", 64'(rx), 64'h60);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("resp_err_clr", 64'(rx), 64'h20);
        bresp_val = 2'b00;
`else
        spi_frame(66, f66(2'b10, 32'h410, 32'h5), rx);
        repeat (50) @(negedge CLK);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("resp_bits_off", 64'(rx), 64'h0);
`endif
        check("resp_aw_cnt", 64'(aw_cnt), 64'd3);

        // Reset while waiting for B: channel handshakes drop and status returns to idle.
        b_dly = 3000;
        spi_frame(66, f66(2'b00, 32'h0, 32'h1), rx);
        spi_frame(66, f66(2'b10, 32'h414, 32'h6), rx);
        repeat (20) @(negedge CLK);
        check("mid_bready", 64'(M_BREADY), 64'h1);
        check("mid_ctrl",   64'(CTRL_OUT), 64'h1);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_bready", 64'(M_BREADY), 64'h0);
        check("mid_rst_ctrl",   64'(CTRL_OUT), 64'h0);
        spi_frame(34, f34(2'b00, 32'h0), rx);
        check("mid_rst_status", 64'(rx), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
